// File: rtl/cw305_reg_bus_master_pkg.sv
// Shared FSM state encodings and error codes for the
// CW305 register-bus master and its timeout helper.
package cw305_reg_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_WAIT,
        ST_WR_STB,
        ST_RD_STB,
        ST_RD_CAP,
        ST_RD_HOLD,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_ZERO_LEN,
        ERR_TIMEOUT
    } err_code_t;

    function automatic logic err_flag(input err_code_t code);
        return code != ERR_NONE;
    endfunction

endpackage

// File: rtl/cw305_reg_bus_master_timeout.sv
// Loadable stall down-counter; expired is raised while the
// master is stalled and the budget since the last reload is spent.
module cw305_reg_bus_master_timeout #(
    parameter int pTIMEOUT = 255
) (
    input  logic usb_clk,
    input  logic reset_i,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(pTIMEOUT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(pTIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt;

    // reload on every strobe, count down only while stalled
    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && cnt != '0) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/cw305_reg_bus_master.sv
// CW305 register-bus initiator: one command -> byte-serial burst.
// Optional stall abort enabled by defining CW_REG_MASTER_TIMEOUT_EN.
module cw305_reg_bus_master
    import cw305_reg_bus_master_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pTIMEOUT      = 255
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_addr,
    input  logic [pBYTECNT_SIZE-1:0]             cmd_len,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [7:0]                           wr_data,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [7:0]                           rd_data,
    output logic                                 rd_last,
    output logic                                 done,
    output logic                                 err,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    input  logic [7:0]                           read_data,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
);

    localparam int BW = pBYTECNT_SIZE;
    localparam logic [BW-1:0] BC_ONE = BW'(1);

    state_t        state;
    logic          is_write;
    logic [BW-1:0] len_q;
    logic [BW-1:0] idx;
    logic          last_byte;
    logic          to_expired;

    assign last_byte = (idx == len_q - BC_ONE);

`ifdef CW_REG_MASTER_TIMEOUT_EN
    logic to_load;
    logic to_run;

    assign to_load = (state == ST_SETUP) || reg_write || reg_read;
    assign to_run  = (state == ST_WR_WAIT) || (state == ST_RD_HOLD);

    cw305_reg_bus_master_timeout #(
        .pTIMEOUT (pTIMEOUT)
    ) u_timeout (
        .usb_clk  (usb_clk),
        .reset_i  (reset_i),
        .load     (to_load),
        .run      (to_run),
        .expired  (to_expired)
    );
`else
    logic unused_timeout;

    assign to_expired     = 1'b0;
    assign unused_timeout = (pTIMEOUT != 0);
`endif

    // burst sequencer; every output is registered and set on state entry
    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            is_write      <= 1'b0;
            len_q         <= '0;
            idx           <= '0;
            cmd_ready     <= 1'b0;
            wr_ready      <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            rd_last       <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            write_data    <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    err <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        is_write    <= cmd_write;
                        len_q       <= cmd_len;
                        idx         <= '0;
                        reg_bytecnt <= '0;
                        reg_address <= cmd_addr;
                        if (cmd_len == '0) begin
                            done  <= 1'b1;
                            err   <= err_flag(ERR_ZERO_LEN);
                            state <= ST_FINISH;
                        end else begin
                            reg_addrvalid <= 1'b1;
                            state         <= ST_SETUP;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (is_write) begin
                        wr_ready <= 1'b1;
                        state    <= ST_WR_WAIT;
                    end else begin
                        reg_read <= 1'b1;
                        state    <= ST_RD_STB;
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_valid) begin
                        write_data <= wr_data;
                        wr_ready   <= 1'b0;
                        reg_write  <= 1'b1;
                        state      <= ST_WR_STB;
                    end else if (to_expired) begin
                        wr_ready      <= 1'b0;
                        reg_addrvalid <= 1'b0;
                        done          <= 1'b1;
                        err           <= err_flag(ERR_TIMEOUT);
                        state         <= ST_FINISH;
                    end
                end
                ST_WR_STB: begin
                    reg_write <= 1'b0;
                    if (last_byte) begin
                        reg_addrvalid <= 1'b0;
                        done          <= 1'b1;
                        err           <= err_flag(ERR_NONE);
                        state         <= ST_FINISH;
                    end else begin
                        idx         <= idx + BC_ONE;
                        reg_bytecnt <= idx + BC_ONE;
                        wr_ready    <= 1'b1;
                        state       <= ST_WR_WAIT;
                    end
                end
                ST_RD_STB: begin
                    reg_read <= 1'b0;
                    state    <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    rd_data  <= read_data;
                    rd_valid <= 1'b1;
                    rd_last  <= last_byte;
                    state    <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (last_byte) begin
                            reg_addrvalid <= 1'b0;
                            done          <= 1'b1;
                            err           <= err_flag(ERR_NONE);
                            state         <= ST_FINISH;
                        end else begin
                            idx         <= idx + BC_ONE;
                            reg_bytecnt <= idx + BC_ONE;
                            reg_read    <= 1'b1;
                            state       <= ST_RD_STB;
                        end
                    end else if (to_expired) begin
                        rd_valid      <= 1'b0;
                        rd_last       <= 1'b0;
                        reg_addrvalid <= 1'b0;
                        done          <= 1'b1;
                        err           <= err_flag(ERR_TIMEOUT);
                        state         <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    err       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw305_reg_bus_master.sv
// Scoreboard bench for cw305_reg_bus_master with a registered
// slave model; the stall-abort case needs CW_REG_MASTER_TIMEOUT_EN.
module tb_cw305_reg_bus_master;

    localparam int AW = 14;
    localparam int BW = 7;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] idx;
        logic [7:0]    data;
    } wr_exp_t;

    logic          usb_clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [7:0]    wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_last;
    logic          done;
    logic          err;
    logic [AW-1:0] reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic [7:0]    write_data;
    logic [7:0]    read_data = '0;
    logic          reg_read;
    logic          reg_write;
    logic          reg_addrvalid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_rd = 0;
    int n_done = 0;
    int n_av = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    logic abort = 1'b0;
    logic [AW-1:0] cur_addr = '0;

    rd_exp_t rdq[$];
    wr_exp_t wrq[$];
    logic    doneq[$];

    logic [7:0] wmem [16];
    logic [7:0] rmem [4];

    always #5 usb_clk = ~usb_clk;

    always @(posedge usb_clk) cyc <= cyc + 1;

    cw305_reg_bus_master #(
        .pADDR_WIDTH   (21),
        .pBYTECNT_SIZE (7),
        .pTIMEOUT      (8)
    ) dut (
        .usb_clk       (usb_clk),
        .reset_i       (reset_i),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .done          (done),
        .err           (err),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .write_data    (write_data),
        .read_data     (read_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid)
    );

    // slave register file: captures writes, returns reads registered
    always @(posedge usb_clk) begin
        if (reg_write && reg_addrvalid) wmem[reg_bytecnt[3:0]] <= write_data;
        if (reg_read) read_data <= rmem[reg_bytecnt[1:0]];
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got event want none", name);
    endtask

    // monitor: pops expectations whenever the DUT presents something
    wr_exp_t    we;
    rd_exp_t    re;
    logic       de;
    logic       av_prev = 1'b0;
    logic       rd_pending = 1'b0;
    logic [7:0] rd_hold = '0;

    always @(negedge usb_clk) begin
        if (!reset_i) begin
            if (reg_write) begin
                n_wr++;
                if (wrq.size() == 0) begin
                    fail("reg_write_unexpected");
                end else begin
                    we = wrq.pop_front();
                    chk("reg_write",
                        {reg_address, reg_bytecnt, write_data,
                         reg_addrvalid, wr_ready},
                        {we.addr, we.idx, we.data, 1'b1, 1'b0});
                end
            end
            if (reg_read) begin
                n_rd++;
                chk("reg_read_addr", {reg_addrvalid, reg_address},
                    {1'b1, cur_addr});
            end
            if (rd_valid) begin
                if (rd_pending) chk("rd_stable", rd_data, rd_hold);
                rd_pending = !rd_ready;
                rd_hold    = rd_data;
                if (rd_ready) begin
                    if (rdq.size() == 0) begin
                        fail("rd_unexpected");
                    end else begin
                        re = rdq.pop_front();
                        chk("rd_byte", {rd_data, rd_last},
                            {re.data, re.last});
                    end
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (doneq.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    de = doneq.pop_front();
                    chk("done_err", err, de);
                end
            end
            if (reg_addrvalid && !av_prev) n_av++;
        end
        av_prev = reg_addrvalid;
    end

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                             input logic [BW-1:0] len, input logic exp_err);
        logic ok;
        ok = 1'b0;
        doneq.push_back(exp_err);
        cur_addr  = addr;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge usb_clk);
            if (cmd_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge usb_clk);
        #1 cmd_valid = 1'b0;
        if (!ok) fail("cmd_accept_timeout");
    endtask

    task automatic send_bytes(input int n, input logic [7:0] first,
                              input int stop_after);
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (i >= stop_after) break;
            wr_valid = 1'b1;
            wr_data  = first + 8'(i);
            ok = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge usb_clk);
                if (abort) begin
                    wr_valid = 1'b0;
                    return;
                end
                if (wr_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail("wr_ready_timeout");
                break;
            end
            wrq.push_back('{addr: cur_addr, idx: BW'(i), data: wr_data});
            @(posedge usb_clk);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic stall_reader(input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge usb_clk);
                if (rd_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail("rd_valid_timeout");
                break;
            end
            repeat (10) @(negedge usb_clk);
            @(posedge usb_clk);
            #1 rd_ready = 1'b1;
            @(posedge usb_clk);
            #1 rd_ready = 1'b0;
        end
    endtask

    task automatic wait_done(input int d0);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge usb_clk);
            if (n_done > d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("done_timeout");
        #1;
    endtask

    task automatic push_reads();
        rdq.push_back('{data: 8'hD4, last: 1'b0});
        rdq.push_back('{data: 8'hC3, last: 1'b0});
        rdq.push_back('{data: 8'hB2, last: 1'b0});
        rdq.push_back('{data: 8'hA1, last: 1'b1});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, r0, a0;
        logic [127:0] tx;
        rmem[0] = 8'hD4;
        rmem[1] = 8'hC3;
        rmem[2] = 8'hB2;
        rmem[3] = 8'hA1;
        for (int i = 0; i < 16; i++) wmem[i] = 8'hFF;

        #1 reset_i = 1'b1;
        repeat (3) @(negedge usb_clk);
        chk("reset_outputs",
            {cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, err,
             reg_address, reg_bytecnt, write_data, reg_read, reg_write,
             reg_addrvalid}, '0);
        @(posedge usb_clk);
        #1 reset_i = 1'b0;
        @(negedge usb_clk);
        chk("cmd_ready_at_release", cmd_ready, 1'b0);
        @(negedge usb_clk);
        chk("cmd_ready_after_release", cmd_ready, 1'b1);
        @(posedge usb_clk);
        #1;

        // 16-byte write, data always valid
        d0 = n_done; w0 = n_wr; a0 = n_av;
        fork
            issue_cmd(1'b1, 14'h06, 7'd16, 1'b0);
            send_bytes(16, 8'h00, 16);
        join
        wait_done(d0);
        for (int i = 0; i < 16; i++) tx[i*8 +: 8] = wmem[i];
        chk("textin", tx, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("wr_strobes", n_wr - w0, 16);
        chk("wr_addrvalid_runs", n_av - a0, 1);
        chk("wr_done_pulses", n_done - d0, 1);

        // 4-byte read, reader always ready
        rd_ready = 1'b1;
        push_reads();
        d0 = n_done; r0 = n_rd; a0 = n_av;
        issue_cmd(1'b0, 14'h0B, 7'd4, 1'b0);
        wait_done(d0);
        chk("rd_strobes", n_rd - r0, 4);
        chk("rd_addrvalid_runs", n_av - a0, 1);
        chk("rd_queue_drained", rdq.size(), 0);

        // 4-byte read, reader stalls 10 clocks per byte
        rd_ready = 1'b0;
        push_reads();
        d0 = n_done; r0 = n_rd;
        fork
            issue_cmd(1'b0, 14'h0B, 7'd4, 1'b0);
            stall_reader(4);
        join
        wait_done(d0);
        chk("rd_stall_strobes", n_rd - r0, 4);
        chk("rd_stall_drained", rdq.size(), 0);

        // zero-length command
        d0 = n_done; w0 = n_wr; r0 = n_rd; a0 = n_av;
        issue_cmd(1'b1, 14'h03, 7'd0, 1'b1);
        wait_done(d0);
        chk("len0_latency_ok",
            (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1'b1);
        chk("len0_no_bus", {n_wr - w0, n_rd - r0, n_av - a0}, '0);

        // reset during byte 5 of a 16-byte write
        d0 = n_done;
        fork
            issue_cmd(1'b1, 14'h06, 7'd16, 1'b0);
            send_bytes(16, 8'h20, 16);
            begin
                logic ok;
                ok = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge usb_clk);
                    if (reg_write && reg_bytecnt == 7'd4) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) fail("byte5_timeout");
                #2 reset_i = 1'b1;
                #1;
                chk("reset_drops_bus",
                    {reg_write, reg_read, reg_addrvalid, done, wr_ready},
                    '0);
                abort = 1'b1;
            end
        join
        doneq.delete();
        wrq.delete();
        repeat (3) @(posedge usb_clk);
        #1 reset_i = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge usb_clk);
        #1;
        chk("no_done_after_reset", n_done - d0, 0);

        d0 = n_done; w0 = n_wr;
        fork
            issue_cmd(1'b1, 14'h09, 7'd2, 1'b0);
            send_bytes(2, 8'h55, 2);
        join
        wait_done(d0);
        chk("post_reset_bytes", {wmem[1], wmem[0]}, 16'h5655);
        chk("post_reset_strobes", n_wr - w0, 2);

`ifdef CW_REG_MASTER_TIMEOUT_EN
        // writer stalls after 2 of 4 bytes
        d0 = n_done; w0 = n_wr;
        fork
            issue_cmd(1'b1, 14'h07, 7'd4, 1'b1);
            send_bytes(4, 8'h40, 2);
        join
        wait_done(d0);
        chk("timeout_strobes", n_wr - w0, 2);
        chk("timeout_addrvalid", reg_addrvalid, 1'b0);
`endif

        chk("done_queue_drained", doneq.size(), 0);
        chk("wr_queue_drained", wrq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
